// File: rtl/node_pkt_serializer_pkg.sv
// Shared types for the node outbound serializer.
// Packet layout, beat count and FSM state encoding.
package node_pkt_serializer_pkg;

  localparam int PKT_BYTES = 4;
  localparam int CNT_W = $clog2(PKT_BYTES);

  typedef struct packed {
    logic [3:0]  src;
    logic [3:0]  dest;
    logic [23:0] data;
  } pkt_t;

  typedef enum logic {
    IDLE,
    SEND
  } ser_state_t;

endpackage

// File: rtl/node_pkt_serializer.sv
// Node outbound stage: pops pkt_t from the FIFO, sends it MSB-first as
// byte beats on put/payload. Ports: clock, reset_n, pkt_in/empty/re, free/put/payload, busy, pkts_sent.
module node_pkt_serializer
  import node_pkt_serializer_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  pkt_t        pkt_in,
  input  logic        pkt_empty,
  output logic        pkt_re,
  input  logic        free_outbound,
  output logic        put_outbound,
  output logic [7:0]  payload_outbound,
  output logic        busy,
  output logic [15:0] pkts_sent
);

  ser_state_t       state_q;
  ser_state_t       state_d;
  logic [31:0]      shreg_q;
  logic [CNT_W-1:0] cnt_q;
  logic [15:0]      sent_q;
  logic             last;

  assign last = (cnt_q == CNT_W'(PKT_BYTES - 1));

  // reset_n gates the pop so the FIFO is never drained during reset
  always_comb begin
    state_d = state_q;
    pkt_re  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (reset_n && !pkt_empty && free_outbound) begin
          pkt_re  = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        if (last) state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      shreg_q <= '0;
      cnt_q   <= '0;
      sent_q  <= '0;
    end else if (pkt_re) begin
      shreg_q <= pkt_in;
      cnt_q   <= '0;
    end else if (state_q == SEND) begin
      shreg_q <= shreg_q << 8;
      cnt_q   <= cnt_q + 1'b1;
      if (last) sent_q <= sent_q + 16'd1;
    end
  end

  // beat outputs decode straight from registered state
  assign put_outbound     = (state_q == SEND);
  assign payload_outbound = put_outbound ? shreg_q[31:24] : 8'h00;
  assign busy             = put_outbound;
  assign pkts_sent        = sent_q;

endmodule
